// File: rtl/int_log.sv
// Integer logarithm: largest E with base^E <= value, by repeated multiplication.
// Optional macro INT_LOG_EXACT_EN builds the exact-power flag; otherwise exact is tied to 0.
module int_log (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] base,
  input  logic [7:0] value,
  output logic [3:0] exp_out,
  output logic       exact,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned BW = 4;
  localparam int unsigned VW = 8;
  localparam int unsigned EW = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned PW = 12;
  localparam logic [EW-1:0] CNT_MAX = EW'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   base_q, base_d;
  logic [VW-1:0]   value_q, value_d;
  logic [AW-1:0]   acc, acc_d;
  logic [EW-1:0]   cnt, cnt_d;
  logic [EW-1:0]   exp_d;
  logic            error_d;
  logic            busy_d;
  logic            done_d;
  logic [PW-1:0]   prod_c;
  logic            op_bad_c;
  logic            run_end_c;

  // acc never exceeds value (<= 255), so the 12-bit product is exact
  assign prod_c    = PW'(acc) * PW'(base_q);
  assign op_bad_c  = (base < BW'(2)) || (value == VW'(0));
  assign run_end_c = (prod_c > PW'(value_q)) || (cnt == CNT_MAX);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      base_q  <= '0;
      value_q <= '0;
      acc     <= AW'(1);
      cnt     <= '0;
      exp_out <= '0;
      error   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      base_q  <= base_d;
      value_q <= value_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      exp_out <= exp_d;
      error   <= error_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = op_bad_c ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (run_end_c) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Register next values; busy/done follow the state being entered
  always_comb begin
    base_d  = base_q;
    value_d = value_q;
    acc_d   = acc;
    cnt_d   = cnt;
    exp_d   = exp_out;
    error_d = error;
    busy_d  = (state_n != S_IDLE);
    done_d  = (state_n == S_DONE);
    unique case (state)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          value_d = value;
          acc_d   = AW'(1);
          cnt_d   = '0;
          exp_d   = '0;
          error_d = op_bad_c;
        end
      end
      S_RUN: begin
        if (run_end_c) begin
          exp_d   = cnt;
          error_d = 1'b0;
        end else begin
          acc_d = AW'(prod_c);
          cnt_d = cnt + EW'(1);
        end
      end
      default: begin
      end
    endcase
  end

`ifdef INT_LOG_EXACT_EN
  logic exact_d;

  always_comb begin
    exact_d = exact;
    if ((state == S_IDLE) && start) begin
      exact_d = 1'b0;
    end else if ((state == S_RUN) && run_end_c) begin
      exact_d = (acc == AW'(value_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact <= 1'b0;
    end else begin
      exact <= exact_d;
    end
  end
`else
  assign exact = 1'b0;
`endif

endmodule

// File: doc/int_log.md
INT_LOG -- requirements
Module: int_log

Interface
REQ-001: Parameters: none; widths are fixed at 4-bit base, 8-bit value and 4-bit exponent.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  request pulse; sampled only in IDLE.
REQ-005: base  input  4  logarithm base A; captured when start is accepted.
REQ-006: value  input  8  operand Y; captured when start is accepted.
REQ-007: exp_out  output  4  result E = largest E with A^E <= Y; registered.
REQ-008: exact  output  1  1 when A^E == Y; registered.
REQ-009: busy  output  1  high from accepted start until done cycle inclusive.
REQ-010: done  output  1  one-cycle result-valid pulse.
REQ-011: error  output  1  invalid operand flag; registered, valid with done.

Function
REQ-012: FSM states are IDLE, RUN and DONE; after reset the FSM is in IDLE.
REQ-013: IDLE with start=1 captures base and value, clears the exponent counter to 0, loads the 9-bit accumulator with 1 and sets busy=1 on that edge.
REQ-014: If the captured base < 2 or value == 0, the FSM goes IDLE->DONE with error=1, exp_out=0 and exact=0, and done is high in the first cycle after the start edge.
REQ-015: Otherwise the FSM goes IDLE->RUN.
REQ-016: Each RUN cycle forms prod = acc*base at 12 bits with no truncation.
REQ-017: In RUN, if prod <= value, then acc<=prod, cnt<=cnt+1, and the FSM stays in RUN.
REQ-018: In RUN, if prod > value, then exp_out<=cnt, exact<=(acc==value), error<=0, and the FSM goes to DONE.
REQ-019: Latency: for result E, the block spends E+1 RUN cycles, and done is high in the cycle E+2 clocks after the start edge; the worst case is base=2, value 128..255, giving 9 cycles.
REQ-020: DONE lasts exactly one cycle with done=1 and busy=1, then the FSM returns to IDLE.
REQ-021: start is ignored in RUN and DONE; it is not queued.
REQ-022: Changes on base or value after capture do not affect the running result.
REQ-023: exp_out, exact and error hold their last values until the next accepted start, which clears them to 0 on the acceptance edge.
REQ-024: cnt saturates at 15; it cannot be reached for legal operands, and reaching it forces completion.

Reset
REQ-025: rst_n=0 immediately forces: FSM to IDLE, exp_out=0, exact=0, busy=0, done=0, error=0, acc=1, cnt=0.
REQ-026: Reset asserted mid-RUN or in DONE aborts the operation with no done pulse; the first start after release is handled normally.
REQ-027: rst_n deassertion takes effect on the next rising edge; a start in that same cycle is accepted.

Configuration
REQ-028: Macro INT_LOG_EXACT_EN controls the exact flag.
REQ-029: With INT_LOG_EXACT_EN defined, exact behaves per REQ-018.
REQ-030: Without INT_LOG_EXACT_EN, exact is tied to 0, no equality comparator is built, and all other behaviour and timing are identical.

Verification
REQ-031: base=2, value=200, start -> done after 9 cycles, exp_out=7, exact=0, error=0.
REQ-032: base=3, value=81 -> exp_out=4, exact=1 (exact=0 when INT_LOG_EXACT_EN is undefined), done 6 cycles after start.
REQ-033: base=15, value=14 -> exp_out=0, exact=0, done 2 cycles after start; base=1, value=50 -> error=1, exp_out=0, done 1 cycle after start.
REQ-034: base=2, value=255, with a second start (base=3) pulsed at cycle 3 -> second start ignored, result exp_out=7, busy continuous until done.
REQ-035: base=2, value=255, rst_n low at cycle 4 -> all outputs 0 immediately, no done pulse; then base=5, value=125 -> exp_out=3, exact=1.
REQ-036: Back-to-back: start held high continuously -> a new operation is accepted on the first IDLE cycle after each done, giving one done per E+3 cycles.
